// File: rtl/decode_pkg.sv
// Shared definitions for the MIPS decode stage: opcodes, control field
// widths, control bit positions and the main control decode function.
package decode_pkg;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // WB field bits
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  // M field bits
  localparam int M_BRANCH   = 2;
  localparam int M_MEMWRITE = 1;
  localparam int M_MEMREAD  = 0;
  // EX field bits
  localparam int EX_ALUOP_HI = 3;
  localparam int EX_ALUOP_LO = 2;
  localparam int EX_REGDST   = 1;
  localparam int EX_ALUSRC   = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  // Main control: unknown opcodes decode to all-zero controls (a NOP).
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.wb[WB_REGWRITE]               = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = 2'b10;
        c.ex[EX_REGDST]                 = 1'b1;
      end
      OP_LW: begin
        c.wb[WB_REGWRITE] = 1'b1;
        c.wb[WB_MEMTOREG] = 1'b1;
        c.m[M_MEMREAD]    = 1'b1;
        c.ex[EX_ALUSRC]   = 1'b1;
      end
      OP_SW: begin
        c.m[M_MEMWRITE] = 1'b1;
        c.ex[EX_ALUSRC] = 1'b1;
      end
      OP_BEQ: begin
        c.m[M_BRANCH]                 = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO] = 2'b01;
      end
      OP_ADDI: begin
        c.wb[WB_REGWRITE] = 1'b1;
        c.ex[EX_ALUSRC]   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file for the decode stage: two combinational read ports, one
// write port, $0 hardwired to zero, write-through bypass so a register
// written this cycle is read with its new value. Synchronous active-low reset.
module decode_regfile #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [31:0] r_regs [NUM_REGS];
  logic        w_wr_en;
  logic        w_hit1;
  logic        w_hit2;

  assign w_wr_en = i_we && (i_waddr != 5'd0);
  assign w_hit1  = w_wr_en && (i_waddr == i_raddr1);
  assign w_hit2  = w_wr_en && (i_waddr == i_raddr2);

  // Storage: cleared on reset, written on enable except for $0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_waddr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 :
                    w_hit1             ? i_wdata : r_regs[i_raddr1[AW-1:0]];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 :
                    w_hit2             ? i_wdata : r_regs[i_raddr2[AW-1:0]];

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: register file, main control decode, load-use hazard
// detection and the registered ID/EX bundle. A bubble is all-zero WB/M/EX.
// Optional macro DECODE_PERF_EN adds saturating stall / issue counters.
module decode_stage
  import decode_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int PC_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      in_IF_ID,
  input  logic             in_wb_reg_write,
  input  logic [4:0]       in_wb_write_reg,
  input  logic [31:0]      in_wb_write_data,
  input  logic             in_ex_mem_read,
  input  logic [4:0]       in_ex_rt,
  input  logic             in_flush,
  output logic             out_stall,
  output logic [WB_W-1:0]  out_WB,
  output logic [M_W-1:0]   out_M,
  output logic [EX_W-1:0]  out_EX,
  output logic [PC_W-1:0]  out_incremented_PC,
  output logic [31:0]      out_regData1,
  output logic [31:0]      out_regData2,
  output logic [31:0]      out_sign_extended_offset,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd
`ifdef DECODE_PERF_EN
  ,
  output logic [15:0]      out_stall_count,
  output logic [15:0]      out_instr_count
`endif
);

  logic [31:0] w_instr;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_sext;
  logic [31:0] w_rdata1;
  logic [31:0] w_rdata2;
  logic        w_stall;
  logic        w_bubble;
  ctrl_t       w_ctrl;

  assign w_instr = in_IF_ID[31:0];
  assign w_rs    = w_instr[25:21];
  assign w_rt    = w_instr[20:16];
  assign w_rd    = w_instr[15:11];
  assign w_sext  = {{16{w_instr[15]}}, w_instr[15:0]};
  assign w_ctrl  = decode_ctrl(w_instr[31:26]);

  // Load-use: gated by rst_n so the stall is never raised during reset
  assign w_stall  = rst_n & in_ex_mem_read & (in_ex_rt != 5'd0) &
                    ((in_ex_rt == w_rs) | (in_ex_rt == w_rt));
  assign w_bubble = in_flush | w_stall;
  assign out_stall = w_stall;

  decode_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2),
    .i_we     (in_wb_reg_write),
    .i_waddr  (in_wb_write_reg),
    .i_wdata  (in_wb_write_data)
  );

  // ID/EX pipeline register; flush or stall zero only the control fields
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_WB                   <= '0;
      out_M                    <= '0;
      out_EX                   <= '0;
      out_incremented_PC       <= '0;
      out_regData1             <= '0;
      out_regData2             <= '0;
      out_sign_extended_offset <= '0;
      out_rt                   <= '0;
      out_rd                   <= '0;
    end else begin
      out_WB                   <= w_bubble ? '0 : w_ctrl.wb;
      out_M                    <= w_bubble ? '0 : w_ctrl.m;
      out_EX                   <= w_bubble ? '0 : w_ctrl.ex;
      out_incremented_PC       <= in_IF_ID[32 +: PC_W];
      out_regData1             <= w_rdata1;
      out_regData2             <= w_rdata2;
      out_sign_extended_offset <= w_sext;
      out_rt                   <= w_rt;
      out_rd                   <= w_rd;
    end
  end

`ifdef DECODE_PERF_EN
  logic [15:0] r_stall_count;
  logic [15:0] r_instr_count;

  // Saturating counters of stall cycles and non-bubble issues
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (w_stall && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
      if (!w_bubble && (r_instr_count != 16'hFFFF))
        r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign out_stall_count = r_stall_count;
  assign out_instr_count = r_instr_count;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table plus
// hand-written sequences for reset, write-through and $0 handling.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_IF_ID;
  logic        in_wb_reg_write;
  logic [4:0]  in_wb_write_reg;
  logic [31:0] in_wb_write_data;
  logic        in_ex_mem_read;
  logic [4:0]  in_ex_rt;
  logic        in_flush;
  logic        out_stall;
  logic [1:0]  out_WB;
  logic [2:0]  out_M;
  logic [3:0]  out_EX;
  logic [31:0] out_incremented_PC;
  logic [31:0] out_regData1;
  logic [31:0] out_regData2;
  logic [31:0] out_sign_extended_offset;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
`ifdef DECODE_PERF_EN
  logic [15:0] out_stall_count;
  logic [15:0] out_instr_count;
`endif

  int n_cmp;
  int n_fail;

  decode_stage dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .in_IF_ID                 (in_IF_ID),
    .in_wb_reg_write          (in_wb_reg_write),
    .in_wb_write_reg          (in_wb_write_reg),
    .in_wb_write_data         (in_wb_write_data),
    .in_ex_mem_read           (in_ex_mem_read),
    .in_ex_rt                 (in_ex_rt),
    .in_flush                 (in_flush),
    .out_stall                (out_stall),
    .out_WB                   (out_WB),
    .out_M                    (out_M),
    .out_EX                   (out_EX),
    .out_incremented_PC       (out_incremented_PC),
    .out_regData1             (out_regData1),
    .out_regData2             (out_regData2),
    .out_sign_extended_offset (out_sign_extended_offset),
    .out_rt                   (out_rt),
    .out_rd                   (out_rd)
`ifdef DECODE_PERF_EN
    ,
    .out_stall_count          (out_stall_count),
    .out_instr_count          (out_instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ex_mr;
    logic [4:0]  ex_rt;
    logic        flush;
    logic        stall;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] d1;
    logic [31:0] d2;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic mr, input logic [4:0] ext, input logic fl);
    in_IF_ID       = {pc, instr};
    in_ex_mem_read = mr;
    in_ex_rt       = ext;
    in_flush       = fl;
  endtask

  task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    in_wb_reg_write  = we;
    in_wb_write_reg  = r;
    in_wb_write_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble_all_zero(input string tag);
    chk({tag, " WB"},   {30'd0, out_WB}, 32'd0);
    chk({tag, " M"},    {29'd0, out_M}, 32'd0);
    chk({tag, " EX"},   {28'd0, out_EX}, 32'd0);
    chk({tag, " PC"},   out_incremented_PC, 32'd0);
    chk({tag, " d1"},   out_regData1, 32'd0);
    chk({tag, " d2"},   out_regData2, 32'd0);
    chk({tag, " imm"},  out_sign_extended_offset, 32'd0);
    chk({tag, " rt"},   {27'd0, out_rt}, 32'd0);
    chk({tag, " rd"},   {27'd0, out_rd}, 32'd0);
  endtask

  initial begin
`ifdef DECODE_PERF_EN
    logic [15:0] exp_sc;
    logic [15:0] exp_ic;
`endif
    n_cmp  = 0;
    n_fail = 0;

    //           instr         pc            mr  ext  fl  stl wb     m       ex       rt  rd  imm           d1            d2
    vt[0]  = '{32'h8D280004, 32'h00000100, 0, 5'd0, 0, 0, 2'b11, 3'b001, 4'b0001, 8,  0,  32'h00000004, 32'h0, 32'h0};
    vt[1]  = '{32'h1022FFFF, 32'h00000104, 0, 5'd0, 0, 0, 2'b00, 3'b100, 4'b0100, 2,  31, 32'hFFFFFFFF, 32'hA, 32'h5};
    vt[2]  = '{32'hAC220008, 32'h00000108, 0, 5'd0, 0, 0, 2'b00, 3'b010, 4'b0001, 2,  0,  32'h00000008, 32'hA, 32'h5};
    vt[3]  = '{32'h2022FFF0, 32'h0000010C, 0, 5'd0, 0, 0, 2'b10, 3'b000, 4'b0001, 2,  31, 32'hFFFFFFF0, 32'hA, 32'h5};
    vt[4]  = '{32'h08000010, 32'h00000110, 0, 5'd0, 0, 0, 2'b00, 3'b000, 4'b0000, 0,  0,  32'h00000010, 32'h0, 32'h0};
    vt[5]  = '{32'h00221820, 32'h00000114, 1, 5'd1, 0, 1, 2'b00, 3'b000, 4'b0000, 2,  3,  32'h00001820, 32'hA, 32'h5};
    vt[6]  = '{32'h00221820, 32'h00000118, 1, 5'd2, 0, 1, 2'b00, 3'b000, 4'b0000, 2,  3,  32'h00001820, 32'hA, 32'h5};
    vt[7]  = '{32'h00221820, 32'h0000011C, 1, 5'd0, 0, 0, 2'b10, 3'b000, 4'b1010, 2,  3,  32'h00001820, 32'hA, 32'h5};
    vt[8]  = '{32'h00221820, 32'h00000120, 0, 5'd1, 0, 0, 2'b10, 3'b000, 4'b1010, 2,  3,  32'h00001820, 32'hA, 32'h5};
    vt[9]  = '{32'h8D280004, 32'h00000124, 1, 5'd9, 1, 1, 2'b00, 3'b000, 4'b0000, 8,  0,  32'h00000004, 32'h0, 32'h0};
    vt[10] = '{32'h00221820, 32'h00000128, 0, 5'd0, 1, 0, 2'b00, 3'b000, 4'b0000, 2,  3,  32'h00001820, 32'hA, 32'h5};

    // Reset held for two cycles with a stall+flush condition present
    rst_n = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    drive(32'h00221820, 32'h00000044, 1'b1, 5'd1, 1'b1);
    #1;
    chk("stall during reset", {31'd0, out_stall}, 32'd0);
    step();
    step();
    chk_bubble_all_zero("reset");
    chk("stall during reset late", {31'd0, out_stall}, 32'd0);
`ifdef DECODE_PERF_EN
    chk("reset stall_count", {16'd0, out_stall_count}, 32'd0);
    chk("reset instr_count", {16'd0, out_instr_count}, 32'd0);
`endif

    // Release; read $5 (rs=rt=5) which must be 0 after reset
    rst_n = 1'b1;
    drive(32'h00A50000, 32'h00000004, 1'b0, 5'd0, 1'b0);
    step();
    chk("read $5 d1", out_regData1, 32'd0);
    chk("read $5 d2", out_regData2, 32'd0);
    chk("read $5 WB", {30'd0, out_WB}, 32'h2);

    // Write $1, then write $2 while add $3,$1,$2 decodes (bypass on rt)
    wb(1'b1, 5'd1, 32'h0000000A);
    drive(32'h00000000, 32'h00000008, 1'b0, 5'd0, 1'b0);
    step();
    wb(1'b1, 5'd2, 32'h00000005);
    drive(32'h00221820, 32'h00000044, 1'b0, 5'd0, 1'b0);
    step();
    wb(1'b0, 5'd0, 32'd0);
    chk("wt d1", out_regData1, 32'h0000000A);
    chk("wt d2", out_regData2, 32'h00000005);
    chk("wt WB", {30'd0, out_WB}, 32'h2);
    chk("wt M",  {29'd0, out_M}, 32'h0);
    chk("wt EX", {28'd0, out_EX}, 32'hA);
    chk("wt rd", {27'd0, out_rd}, 32'd3);
    chk("wt PC", out_incremented_PC, 32'h00000044);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].instr, vt[i].pc, vt[i].ex_mr, vt[i].ex_rt, vt[i].flush);
`ifdef DECODE_PERF_EN
      exp_sc = out_stall_count + (vt[i].stall ? 16'd1 : 16'd0);
      exp_ic = out_instr_count + ((vt[i].stall || vt[i].flush) ? 16'd0 : 16'd1);
`endif
      #1;
      chk($sformatf("v%0d stall", i), {31'd0, out_stall}, {31'd0, vt[i].stall});
      step();
      chk($sformatf("v%0d WB", i),  {30'd0, out_WB}, {30'd0, vt[i].wb});
      chk($sformatf("v%0d M", i),   {29'd0, out_M},  {29'd0, vt[i].m});
      chk($sformatf("v%0d EX", i),  {28'd0, out_EX}, {28'd0, vt[i].ex});
      chk($sformatf("v%0d rt", i),  {27'd0, out_rt}, {27'd0, vt[i].rt});
      chk($sformatf("v%0d rd", i),  {27'd0, out_rd}, {27'd0, vt[i].rd});
      chk($sformatf("v%0d imm", i), out_sign_extended_offset, vt[i].imm);
      chk($sformatf("v%0d PC", i),  out_incremented_PC, vt[i].pc);
      chk($sformatf("v%0d d1", i),  out_regData1, vt[i].d1);
      chk($sformatf("v%0d d2", i),  out_regData2, vt[i].d2);
`ifdef DECODE_PERF_EN
      chk($sformatf("v%0d stall_count", i), {16'd0, out_stall_count}, {16'd0, exp_sc});
      chk($sformatf("v%0d instr_count", i), {16'd0, out_instr_count}, {16'd0, exp_ic});
`endif
    end

    // Write 0xDEADBEEF to $0 while reading $0; then read $0 again
    wb(1'b1, 5'd0, 32'hDEADBEEF);
    drive(32'h00000000, 32'h00000200, 1'b0, 5'd0, 1'b0);
    step();
    wb(1'b0, 5'd0, 32'd0);
    chk("$0 same-cycle d1", out_regData1, 32'd0);
    chk("$0 same-cycle d2", out_regData2, 32'd0);
    step();
    chk("$0 later d1", out_regData1, 32'd0);
    chk("$0 later d2", out_regData2, 32'd0);

    // $1/$2 retained after unrelated cycles
    drive(32'h00221820, 32'h00000204, 1'b0, 5'd0, 1'b0);
    step();
    chk("retain d1", out_regData1, 32'h0000000A);
    chk("retain d2", out_regData2, 32'h00000005);

    // Reset arriving mid-stall and mid-flush
    drive(32'h00221820, 32'h00000300, 1'b1, 5'd1, 1'b1);
    #1;
    chk("pre-reset stall", {31'd0, out_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-stall reset stall", {31'd0, out_stall}, 32'd0);
    step();
    chk_bubble_all_zero("mid reset");
    rst_n = 1'b1;
    drive(32'h00221820, 32'h00000304, 1'b0, 5'd0, 1'b0);
    step();
    chk("post-reset $1", out_regData1, 32'd0);
    chk("post-reset $2", out_regData2, 32'd0);
    chk("post-reset EX", {28'd0, out_EX}, 32'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
